pwm_meas: RTL and testbench



---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_meas_sync_edge.sv | 30 +++
 rtl/pwm_meas.sv | 81 ++++++++
 tb/tb_pwm_meas.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM measurement block.
package pwm_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Nominal period of the companion 10-bit PWM generator, in clk cycles.
  localparam int PWM_PERIOD    = 1024;
  localparam int CNT_W_DEFAULT = 11;

endpackage

// File: rtl/pwm_meas_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a history flop for edge detection.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_meas.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input, with stuck-line detection.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_sig,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_vld,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             lvl, rise, fall;
  state_t           state;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] per_next, hi_next;
  logic             timeout;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (PWM_sig),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increments: counters park at MAX instead of wrapping.
  assign per_next = (per_cnt == MAX) ? per_cnt : per_cnt + ONE;
  assign hi_next  = (hi_cnt  == MAX) ? hi_cnt  : hi_cnt  + ONE;
  assign timeout  = (per_cnt == MAX) && !rise && !fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SYNC;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_vld   <= 1'b0;
      stuck      <= 1'b0;
      stuck_lvl  <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      per_cnt  <= per_next;
      if (state == HIGH && lvl) hi_cnt <= hi_next;

      // A rise always restarts the counters; only a rise from LOW closes a full period.
      if (rise) begin
        per_cnt <= ONE;
        hi_cnt  <= ONE;
        state   <= HIGH;
        if (state == LOW) begin
          high_cnt   <= hi_cnt;
          period_cnt <= per_cnt;
          meas_vld   <= 1'b1;
          stuck      <= 1'b0;
        end
      end else if (fall) begin
        case (state)
          SYNC:    per_cnt <= ONE;
          HIGH:    state   <= LOW;
          default: state   <= state;
        endcase
      end else if (timeout) begin
        // per_cnt stays at MAX, so re-entry here only rewrites the same values.
        stuck     <= 1'b1;
        stuck_lvl <= lvl;
        state     <= SYNC;
      end
    end
  end

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: periods, duty sweep, stuck detection, saturation boundary, reset.
module tb_pwm_meas;
  import pwm_pkg::*;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwm_sig = 1'b0;
  logic [W-1:0] high_cnt, period_cnt;
  logic         meas_vld, stuck, stuck_lvl;

  int n_checks = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int dbl_cnt  = 0;
  logic prev_vld = 1'b0;
  int q_hi[$];
  int q_per[$];

  pwm_meas #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PWM_sig    (pwm_sig),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_vld   (meas_vld),
    .stuck      (stuck),
    .stuck_lvl  (stuck_lvl)
  );

  always #5 clk = ~clk;

  // Record every report and flag back-to-back valid pulses.
  always @(negedge clk) begin
    if (meas_vld) begin
      vld_cnt++;
      q_hi.push_back(int'(high_cnt));
      q_per.push_back(int'(period_cnt));
      if (prev_vld) dbl_cnt++;
    end
    prev_vld = meas_vld;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    pwm_sig = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    dbl_cnt = 0;
    q_hi.delete();
    q_per.delete();
  endtask

  task automatic drive_period(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      pwm_sig = (i < hi);
    end
  endtask

  // Starts one more period so the preceding one gets reported, then returns low.
  task automatic tail_rise();
    @(negedge clk);
    pwm_sig = 1'b1;
    repeat (8) @(negedge clk);
    pwm_sig = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int vc;
    logic seen;

    // Reset and nominal 513/1024 periods
    do_reset();
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_meas_vld", meas_vld, 0);
    check("rst_stuck", stuck, 0);
    check("rst_stuck_lvl", stuck_lvl, 0);
    drive_period(513, PWM_PERIOD);
    check("nom_no_vld_first_rise", vld_cnt, 0);
    repeat (3) drive_period(513, PWM_PERIOD);
    tail_rise();
    check("nom_vld_count", vld_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nom_hi[%0d]", i), q_hi[i], 32'h201);
      check($sformatf("nom_per[%0d]", i), q_per[i], 32'h400);
    end
    check("nom_stuck", stuck, 0);
    check("nom_double_vld", dbl_cnt, 0);

    // Duty sweep 1, 2, 1023 after a warm-up period
    do_reset();
    drive_period(5, PWM_PERIOD);
    drive_period(1, PWM_PERIOD);
    drive_period(2, PWM_PERIOD);
    drive_period(1023, PWM_PERIOD);
    tail_rise();
    check("sweep_vld_count", vld_cnt, 4);
    check("sweep_hi_warm", q_hi[0], 5);
    check("sweep_hi_1", q_hi[1], 1);
    check("sweep_hi_2", q_hi[2], 2);
    check("sweep_hi_1023", q_hi[3], 1023);
    for (int i = 1; i < 4; i++) check($sformatf("sweep_per[%0d]", i), q_per[i], 1024);
    check("sweep_double_vld", dbl_cnt, 0);

    // Stuck high after a valid period, then recovery
    do_reset();
    drive_period(513, PWM_PERIOD);
    drive_period(513, PWM_PERIOD);
    @(negedge clk);
    pwm_sig = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (meas_vld) seen = 1'b1;
    end
    check("hold1_vld_seen", seen, 1);
    repeat (2046) @(negedge clk);
    check("hold1_stuck_before", stuck, 0);
    @(negedge clk);
    check("hold1_stuck", stuck, 1);
    check("hold1_stuck_lvl", stuck_lvl, 1);
    check("hold1_high_kept", high_cnt, 513);
    check("hold1_period_kept", period_cnt, 1024);
    pwm_sig = 1'b0;
    repeat (20) @(negedge clk);
    check("hold1_fall_still_stuck", stuck, 1);
    vc = vld_cnt;
    drive_period(300, 1000);
    check("hold1_no_vld_first_rise", vld_cnt, vc);
    check("hold1_stuck_first_rise", stuck, 1);
    drive_period(300, 1000);
    tail_rise();
    check("hold1_recover_vld", vld_cnt, vc + 2);
    check("hold1_recover_stuck", stuck, 0);
    check("hold1_recover_high", high_cnt, 300);
    check("hold1_recover_period", period_cnt, 1000);

    // Stuck low straight out of reset
    do_reset();
    repeat (2047) @(negedge clk);
    check("hold0_stuck_before", stuck, 0);
    @(negedge clk);
    check("hold0_stuck", stuck, 1);
    check("hold0_stuck_lvl", stuck_lvl, 0);
    check("hold0_no_vld", vld_cnt, 0);

    // Period exactly MAX: rise beats the timeout
    do_reset();
    drive_period(100, 2047);
    drive_period(100, 2047);
    tail_rise();
    check("max_vld_count", vld_cnt, 2);
    check("max_per0", q_per[0], 2047);
    check("max_hi0", q_hi[0], 100);
    check("max_per1", q_per[1], 2047);
    check("max_stuck", stuck, 0);

    // Period MAX+1: times out, never reported
    do_reset();
    drive_period(100, 2048);
    drive_period(100, 2048);
    tail_rise();
    check("over_vld_count", vld_cnt, 0);
    check("over_stuck", stuck, 1);
    check("over_period_cnt", period_cnt, 0);

    // One-cycle reset in the middle of a high phase
    do_reset();
    drive_period(513, PWM_PERIOD);
    drive_period(513, PWM_PERIOD);
    check("mid_pre_high", high_cnt, 513);
    @(negedge clk);
    pwm_sig = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    pwm_sig = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_high", high_cnt, 0);
    check("mid_rst_period", period_cnt, 0);
    check("mid_rst_vld", meas_vld, 0);
    check("mid_rst_stuck", stuck, 0);
    vc = vld_cnt;
    repeat (50) @(negedge clk);
    drive_period(513, PWM_PERIOD);
    check("mid_no_vld_first_rise", vld_cnt, vc);
    drive_period(513, PWM_PERIOD);
    tail_rise();
    check("mid_vld_count", vld_cnt, vc + 2);
    check("mid_high", high_cnt, 513);
    check("mid_period", period_cnt, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
